// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises core and loader accesses onto the single shared data RAM.
// Latency: req seen in IDLE at edge N -> RAM access (GNT) in cycle N+1, *_ready pulse in cycle N+2; one access per 3 cycles.
// Backpressure: a requester holds req and its fields stable until its *_ready; the loser of a tie keeps waiting, nothing is dropped.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   core_req/we/addr/wdata        core request (held until core_ready)
//   core_ready, core_rdata        one-cycle completion pulse, registered read data (held)
//   ldr_req/we/addr/wdata         loader request, same rules as core
//   ldr_ready, ldr_rdata          loader completion pulse and read data
//   ram_we/addr/wdata, ram_rdata  RAM port (driven only in GNT), combinational read data
//   busy                          high while an access is in flight (GNT or ACK)
//
// Build option: define MEM_ARB_RR_EN for round-robin tie breaking; otherwise the core always wins ties.
module mem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_ready,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_ready,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT  = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              sel_q, sel_d;        // 0 = core owns the access, 1 = loader
  logic              core_ready_q, core_ready_d;
  logic              ldr_ready_q, ldr_ready_d;
  logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
  logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;
  logic              tie_pick;
  logic              winner;
  logic              sel_we;

`ifdef MEM_ARB_RR_EN
  logic              last_q, last_d;      // most recent winner; the other side wins the next tie
  assign tie_pick = ~last_q;
`else
  assign tie_pick = 1'b0;
`endif

  // Lone requester wins outright; a tie is settled by tie_pick.
  assign winner = (core_req && ldr_req) ? tie_pick : ldr_req;
  assign sel_we = sel_q ? ldr_we : core_we;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    core_ready_d = 1'b0;
    ldr_ready_d  = 1'b0;
    core_rdata_d = core_rdata_q;
    ldr_rdata_d  = ldr_rdata_q;
    ram_we       = 1'b0;
    ram_addr     = '0;
    ram_wdata    = '0;
`ifdef MEM_ARB_RR_EN
    last_d       = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (core_req || ldr_req) begin
          sel_d   = winner;
          state_d = GNT;
`ifdef MEM_ARB_RR_EN
          last_d  = winner;
`endif
        end
      end
      GNT: begin
        ram_addr  = sel_q ? ldr_addr  : core_addr;
        ram_wdata = sel_q ? ldr_wdata : core_wdata;
        // Reset mid-access must not corrupt RAM, so the write strobe is gated by rst directly.
        ram_we    = sel_we & ~rst;
        if (!sel_we) begin
          if (sel_q) ldr_rdata_d  = ram_rdata;
          else       core_rdata_d = ram_rdata;
        end
        if (sel_q) ldr_ready_d  = 1'b1;
        else       core_ready_d = 1'b1;
        state_d = ACK;
      end
      ACK: begin
        // Requests are not sampled here, so a req still held from this access is ignored.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= 1'b0;
      core_ready_q <= 1'b0;
      ldr_ready_q  <= 1'b0;
      core_rdata_q <= '0;
      ldr_rdata_q  <= '0;
`ifdef MEM_ARB_RR_EN
      last_q       <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      core_ready_q <= core_ready_d;
      ldr_ready_q  <= ldr_ready_d;
      core_rdata_q <= core_rdata_d;
      ldr_rdata_q  <= ldr_rdata_d;
`ifdef MEM_ARB_RR_EN
      last_q       <= last_d;
`endif
    end
  end

  assign core_ready = core_ready_q;
  assign ldr_ready  = ldr_ready_q;
  assign core_rdata = core_rdata_q;
  assign ldr_rdata  = ldr_rdata_q;
  assign busy       = (state_q != IDLE);

endmodule
